// File: rtl/icache_pkg.sv
// Shared icache definitions: miss-handler FSM states, f2 op codes and address field widths.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    FILL
  } ic_state_e;

  localparam logic [2:0] IC_OP_FILL  = 3'b100;
  localparam logic [2:0] IC_OP_FETCH = 3'b001;

  localparam int unsigned IC_SET_CNT    = 1024;
  localparam int unsigned IC_CACHE_LINE = 512;
  localparam int unsigned IC_ADDR_SZ    = 32;

  localparam int unsigned IC_IDX_W       = $clog2(IC_SET_CNT);
  localparam int unsigned IC_OFF_W       = $clog2(IC_CACHE_LINE);
  localparam int unsigned IC_TAG_W       = IC_ADDR_SZ - IC_IDX_W - IC_OFF_W;
  localparam int unsigned IC_LINE_ADDR_W = IC_TAG_W + IC_IDX_W;

endpackage

// File: rtl/icache_mshr_fifo.sv
// Circular FIFO of outstanding miss line addresses with per-entry valid,
// parallel line match and flush-clear that can optionally spare the in-flight head.
module icache_mshr_fifo #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned LINE_W = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_in,
  input  logic [LINE_W-1:0] push_line_in,
  input  logic              pop_in,
  input  logic              flush_in,
  input  logic              keep_head_in,
  input  logic [LINE_W-1:0] cmp_line_in,
  input  logic              head_excl_in,
  output logic              match_out,
  output logic              full_out,
  output logic              any_valid_out,
  output logic              head_valid_out,
  output logic [LINE_W-1:0] head_line_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [LINE_W-1:0] line_q [DEPTH];
  logic [LINE_W-1:0] line_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;

  // Entries are contiguous from head, so the tail slot is occupied only when full.
  assign full_out       = valid_q[tail_q];
  assign any_valid_out  = |valid_q;
  assign head_valid_out = valid_q[head_q];
  assign head_line_out  = line_q[head_q];

  always_comb begin
    match_out = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[PTR_W'(i)] && (line_q[PTR_W'(i)] == cmp_line_in) &&
          !(head_excl_in && (PTR_W'(i) == head_q))) begin
        match_out = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      line_d[i] = line_q[i];
    end
    if (pop_in) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (push_in) begin
      valid_d[tail_q] = 1'b1;
      line_d[tail_q]  = push_line_in;
      tail_d          = tail_q + PTR_W'(1);
    end
    if (flush_in) begin
      valid_d = '0;
      if (keep_head_in && !pop_in) begin
        valid_d[head_q] = valid_q[head_q];
        tail_d          = head_q + PTR_W'(1);
      end else begin
        tail_d = head_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        line_q[i] <= line_d[i];
      end
    end
  end

endmodule

// File: rtl/icache_miss_handler.sv
// Icache miss handler: merges duplicate line misses, issues one L2 line read at a time
// and returns each line to f2 as an L2 fill.
module icache_miss_handler
  import icache_pkg::*;
#(
  parameter int unsigned SET_CNT    = IC_SET_CNT,
  parameter int unsigned CACHE_LINE = IC_CACHE_LINE,
  parameter int unsigned ADDR_SZ    = IC_ADDR_SZ,
  parameter int unsigned MSHR_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid_in,
  input  logic [ADDR_SZ-1:0]    miss_addr_in,
  output logic                  miss_ready_out,
  input  logic                  flush_in,
  output logic                  l2_req_valid_out,
  output logic [ADDR_SZ-1:0]    l2_req_addr_out,
  input  logic                  l2_req_ready_in,
  input  logic                  l2_resp_valid_in,
  input  logic [CACHE_LINE-1:0] l2_resp_data_in,
  output logic                  fill_valid_out,
  output logic [ADDR_SZ-1:0]    fill_addr_out,
  output logic [CACHE_LINE-1:0] fill_data_out,
  output logic [2:0]            fill_op_out,
  input  logic                  fill_ready_in,
  output logic                  busy_out
);

  localparam int unsigned OFF_W  = $clog2(CACHE_LINE);
  localparam int unsigned IDX_W  = $clog2(SET_CNT);
  localparam int unsigned TAG_W  = ADDR_SZ - OFF_W - IDX_W;
  localparam int unsigned LINE_W = TAG_W + IDX_W;

  ic_state_e             state_q, state_d;
  logic                  squash_q, squash_d;
  logic                  req_valid_q, req_valid_d;
  logic                  fill_valid_q, fill_valid_d;
  logic [ADDR_SZ-1:0]    line_addr_q, line_addr_d;
  logic [CACHE_LINE-1:0] line_q, line_d;
  logic [2:0]            fill_op_q, fill_op_d;

  logic [LINE_W-1:0] miss_line, head_line;
  logic              head_valid, any_valid, full, match;
  logic              push, pop, keep_head;
  logic              unused_off;

  assign miss_line      = {miss_addr_in[ADDR_SZ-1 -: TAG_W], miss_addr_in[OFF_W +: IDX_W]};
  assign unused_off     = ^miss_addr_in[OFF_W-1:0];
  assign miss_ready_out = !flush_in && (!full || match);
  assign push           = miss_valid_in && miss_ready_out && !match;

  icache_mshr_fifo #(
    .DEPTH  (MSHR_DEPTH),
    .LINE_W (LINE_W)
  ) u_mshr (
    .clk            (clk),
    .rst            (rst),
    .push_in        (push),
    .push_line_in   (miss_line),
    .pop_in         (pop),
    .flush_in       (flush_in),
    .keep_head_in   (keep_head),
    .cmp_line_in    (miss_line),
    .head_excl_in   (squash_q),
    .match_out      (match),
    .full_out       (full),
    .any_valid_out  (any_valid),
    .head_valid_out (head_valid),
    .head_line_out  (head_line)
  );

  always_comb begin
    state_d     = state_q;
    squash_d    = squash_q;
    line_addr_d = line_addr_q;
    line_d      = line_q;
    pop         = 1'b0;
    keep_head   = 1'b0;
    case (state_q)
      IDLE: begin
        if (head_valid && !flush_in) begin
          state_d     = REQ;
          line_addr_d = {head_line, {OFF_W{1'b0}}};
        end
      end
      REQ: begin
        // A handshake in the flush cycle already reached L2, so it is tracked as squashed.
        if (l2_req_ready_in) begin
          state_d   = WAIT;
          squash_d  = flush_in;
          keep_head = 1'b1;
        end else if (flush_in) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        keep_head = 1'b1;
        if (l2_resp_valid_in) begin
          line_d   = l2_resp_data_in;
          squash_d = 1'b0;
          if (squash_q || flush_in) begin
            state_d = IDLE;
            pop     = 1'b1;
          end else begin
            state_d = FILL;
          end
        end else if (flush_in) begin
          squash_d = 1'b1;
        end
      end
      FILL: begin
        if (flush_in) begin
          state_d = IDLE;
        end else if (fill_ready_in) begin
          state_d = IDLE;
          pop     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    req_valid_d  = (state_d == REQ);
    fill_valid_d = (state_d == FILL);
    fill_op_d    = fill_valid_d ? IC_OP_FILL : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      squash_q     <= 1'b0;
      req_valid_q  <= 1'b0;
      fill_valid_q <= 1'b0;
      line_addr_q  <= '0;
      line_q       <= '0;
      fill_op_q    <= '0;
    end else begin
      state_q      <= state_d;
      squash_q     <= squash_d;
      req_valid_q  <= req_valid_d;
      fill_valid_q <= fill_valid_d;
      line_addr_q  <= line_addr_d;
      line_q       <= line_d;
      fill_op_q    <= fill_op_d;
    end
  end

  assign l2_req_valid_out = req_valid_q;
  assign l2_req_addr_out  = line_addr_q;
  assign fill_valid_out   = fill_valid_q;
  assign fill_addr_out    = line_addr_q;
  assign fill_data_out    = line_q;
  assign fill_op_out      = fill_op_q;
  assign busy_out         = any_valid || (state_q != IDLE);

  a_resp_only_in_wait: assert property (
    @(posedge clk) disable iff (rst) l2_resp_valid_in |-> (state_q == WAIT)
  );

endmodule
